// File: rtl/phy_pkg.sv
// phy_pkg: definitions shared by the 64b/66b receive-path blocks.
//   SYNC_DATA / SYNC_CTRL : the two legal 2-bit sync header encodings.
//   blk_lock_state_t      : block-lock state machine encoding.
//   *_DEF constants       : default lock/unlock thresholds.
//   sh_valid()            : true when a received header is one of the legal encodings.
package phy_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam int GOOD_N_DEF      = 64;
  localparam int BAD_N_DEF       = 16;
  localparam int SLIP_WAIT_N_DEF = 2;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2,
    WAIT   = 2'd3
  } blk_lock_state_t;

  function automatic logic sh_valid(input logic [1:0] sh);
    return (sh == SYNC_DATA) || (sh == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/sat_cnt.sv
// sat_cnt: saturating up-counter with synchronous clear.
//   clk, reset : clock, asynchronous active-high reset.
//   clr        : clear to zero (wins over inc).
//   inc        : increment by one unless already at LIMIT.
//   cnt_o      : current count (registered).
//   max_o      : count equals LIMIT.
module sat_cnt #(
  parameter int W     = 7,
  parameter int LIMIT = 63
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt_o,
  output logic         max_o
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  assign max_o = (cnt_q == W'(LIMIT));
  assign cnt_o = cnt_q;

  // Next count: clear has priority, increment holds at LIMIT.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !max_o) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/block_sync_rx.sv
// block_sync_rx: 64b/66b block-lock stage between the RX gearbox and the descrambler.
//   clk, reset : clock, asynchronous active-high reset.
//   valid_i    : sh_i holds a block's sync header this cycle.
//   sh_i       : received 2-bit sync header.
//   lock_o     : block lock acquired (registered).
//   slip_o     : one-cycle request to shift the gearbox boundary by one bit (registered).
//   sh_cnt_o   : header count in the current acquisition/window, zero-extended (debug).
import phy_pkg::*;

module block_sync_rx #(
  parameter int GOOD_N      = GOOD_N_DEF,
  parameter int BAD_N       = BAD_N_DEF,
  parameter int SLIP_WAIT_N = SLIP_WAIT_N_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_i,
  input  logic [1:0] sh_i,
  output logic       lock_o,
  output logic       slip_o,
  output logic [6:0] sh_cnt_o
);

  localparam int SH_W   = $clog2(GOOD_N + 1);
  localparam int INV_W  = $clog2(BAD_N + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT_N + 1);

  blk_lock_state_t state_d, state_q;
  logic lock_d, lock_q;
  logic slip_d, slip_q;
  logic hdr_ok;

  logic sh_clr, sh_inc, sh_max;
  logic inv_clr, inv_inc, inv_max;
  logic wait_clr, wait_inc, wait_max;
  logic [SH_W-1:0]   sh_cnt;
  logic [INV_W-1:0]  inv_cnt;
  logic [WAIT_W-1:0] wait_cnt;

  // The counters flag the value one below the threshold, so the header that
  // completes a count is detected on the same edge that samples it and the
  // counter is cleared instead of ever holding GOOD_N / BAD_N.
  sat_cnt #(.W(SH_W), .LIMIT(GOOD_N - 1)) u_sh_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (sh_clr),
    .inc   (sh_inc),
    .cnt_o (sh_cnt),
    .max_o (sh_max)
  );

  sat_cnt #(.W(INV_W), .LIMIT(BAD_N - 1)) u_inv_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (inv_clr),
    .inc   (inv_inc),
    .cnt_o (inv_cnt),
    .max_o (inv_max)
  );

  // WAIT covers the cycle in which slip_o is high plus SLIP_WAIT_N ignored
  // cycles, giving a slip-to-slip spacing of SLIP_WAIT_N+2.
  sat_cnt #(.W(WAIT_W), .LIMIT(SLIP_WAIT_N)) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (wait_clr),
    .inc   (wait_inc),
    .cnt_o (wait_cnt),
    .max_o (wait_max)
  );

  assign hdr_ok   = sh_valid(sh_i);
  assign lock_o   = lock_q;
  assign slip_o   = slip_q;
  assign sh_cnt_o = 7'(sh_cnt);

  // Block-lock next-state, counter control and output logic.
  always_comb begin
    state_d  = state_q;
    lock_d   = lock_q;
    slip_d   = 1'b0;
    sh_clr   = 1'b0;
    sh_inc   = 1'b0;
    inv_clr  = 1'b0;
    inv_inc  = 1'b0;
    wait_clr = 1'b0;
    wait_inc = 1'b0;

    case (state_q)
      INIT: begin
        sh_clr   = 1'b1;
        inv_clr  = 1'b1;
        wait_clr = 1'b1;
        lock_d   = 1'b0;
        state_d  = ACQ;
      end

      ACQ: begin
        if (valid_i) begin
          if (!hdr_ok) begin
            slip_d   = 1'b1;
            sh_clr   = 1'b1;
            inv_clr  = 1'b1;
            wait_clr = 1'b1;
            state_d  = WAIT;
          end else if (sh_max) begin
            lock_d  = 1'b1;
            sh_clr  = 1'b1;
            inv_clr = 1'b1;
            state_d = LOCKED;
          end else begin
            sh_inc = 1'b1;
          end
        end else begin
          state_d = ACQ;
        end
      end

      LOCKED: begin
        if (valid_i) begin
          // Loss of lock is checked first so it beats a window restart.
          if (!hdr_ok && inv_max) begin
            lock_d   = 1'b0;
            slip_d   = 1'b1;
            sh_clr   = 1'b1;
            inv_clr  = 1'b1;
            wait_clr = 1'b1;
            state_d  = WAIT;
          end else if (sh_max) begin
            sh_clr  = 1'b1;
            inv_clr = 1'b1;
          end else begin
            sh_inc  = 1'b1;
            inv_inc = !hdr_ok;
          end
        end else begin
          state_d = LOCKED;
        end
      end

      WAIT: begin
        lock_d = 1'b0;
        if (wait_max) begin
          wait_clr = 1'b1;
          state_d  = ACQ;
        end else begin
          wait_inc = 1'b1;
        end
      end

      default: begin
        lock_d   = 1'b0;
        sh_clr   = 1'b1;
        inv_clr  = 1'b1;
        wait_clr = 1'b1;
        state_d  = INIT;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      lock_q  <= 1'b0;
      slip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      slip_q  <= slip_d;
    end
  end

endmodule

// File: tb/tb_block_sync_rx.sv
// tb_block_sync_rx: scoreboard bench for block_sync_rx.
// The driver applies one input vector per cycle and pushes the expected
// post-edge outputs, computed by a small reference model, into a queue; a
// monitor pops one entry per clock edge and compares. Directed spot checks
// against hand-computed constants cover the timing points of each scenario.
module tb_block_sync_rx;

  localparam int G  = 64;
  localparam int B  = 16;
  localparam int SW = 2;

  localparam int S_INIT = 0;
  localparam int S_ACQ  = 1;
  localparam int S_LOCK = 2;
  localparam int S_WAIT = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_i;
  logic [1:0] sh_i;
  logic       lock_o;
  logic       slip_o;
  logic [6:0] sh_cnt_o;

  always #5 clk = ~clk;

  block_sync_rx #(.GOOD_N(G), .BAD_N(B), .SLIP_WAIT_N(SW)) dut (
    .clk      (clk),
    .reset    (reset),
    .valid_i  (valid_i),
    .sh_i     (sh_i),
    .lock_o   (lock_o),
    .slip_o   (slip_o),
    .sh_cnt_o (sh_cnt_o)
  );

  typedef struct packed {
    logic       lock;
    logic       slip;
    logic [6:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   slip_seen = 0;

  int   m_st, m_sh, m_inv, m_wait;
  logic m_lock, m_slip;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_st = S_INIT; m_sh = 0; m_inv = 0; m_wait = 0;
    m_lock = 1'b0; m_slip = 1'b0;
  endtask

  // Reference behaviour for one clock edge with the given inputs.
  task automatic model_step(input logic v, input logic [1:0] sh);
    logic good;
    int   sh_n, inv_n;
    good   = (sh == 2'b01) || (sh == 2'b10);
    m_slip = 1'b0;
    if (m_st == S_INIT) begin
      m_st = S_ACQ; m_sh = 0; m_inv = 0; m_wait = 0; m_lock = 1'b0;
    end else if (m_st == S_ACQ) begin
      if (v && !good) begin
        m_slip = 1'b1; m_sh = 0; m_inv = 0; m_wait = 0; m_st = S_WAIT;
      end else if (v) begin
        m_sh = m_sh + 1;
        if (m_sh == G) begin
          m_lock = 1'b1; m_sh = 0; m_inv = 0; m_st = S_LOCK;
        end
      end
    end else if (m_st == S_LOCK) begin
      if (v) begin
        sh_n  = m_sh + 1;
        inv_n = m_inv + (good ? 0 : 1);
        if (inv_n == B) begin
          m_lock = 1'b0; m_slip = 1'b1; m_sh = 0; m_inv = 0; m_wait = 0; m_st = S_WAIT;
        end else if (sh_n == G) begin
          m_sh = 0; m_inv = 0;
        end else begin
          m_sh = sh_n; m_inv = inv_n;
        end
      end
    end else begin
      if (m_wait == SW) begin
        m_wait = 0; m_st = S_ACQ;
      end else begin
        m_wait = m_wait + 1;
      end
    end
  endtask

  task automatic drive_push(input logic v, input logic [1:0] sh);
    exp_t e;
    valid_i = v;
    sh_i    = sh;
    model_step(v, sh);
    e.lock = m_lock;
    e.slip = m_slip;
    e.cnt  = 7'(m_sh);
    exp_q.push_back(e);
  endtask

  task automatic step(input logic v, input logic [1:0] sh);
    @(negedge clk);
    drive_push(v, sh);
  endtask

  // Valid headers alternating data/control.
  task automatic run_valid(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, (i % 2 == 0) ? 2'b01 : 2'b10);
    end
  endtask

  // Invalid headers alternating 00/11.
  task automatic run_invalid(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, (i % 2 == 0) ? 2'b00 : 2'b11);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expected entry per edge, compared just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if ({lock_o, slip_o, sh_cnt_o} !== e) begin
        n_fail++;
        $display("FAIL scoreboard: got lock=%b slip=%b cnt=%0d, expected lock=%b slip=%b cnt=%0d (t=%0t)",
                 lock_o, slip_o, sh_cnt_o, e.lock, e.slip, e.cnt, $time);
      end
      if (slip_o === 1'b1) slip_seen++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    valid_i = 1'b0;
    sh_i    = 2'b00;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("reset_lock", lock_o, 0);
    chk("reset_slip", slip_o, 0);
    chk("reset_cnt", sh_cnt_o, 0);

    // Release reset; first edge is the INIT step.
    @(negedge clk);
    reset = 1'b0;
    drive_push(1'b0, 2'b00);
    slip_seen = 0;

    // Clean lock: lock visible after the 65th edge (cycle 66).
    run_valid(63);
    settle();
    chk("clean_63_lock", lock_o, 0);
    chk("clean_63_cnt", sh_cnt_o, 63);
    run_valid(1);
    settle();
    chk("clean_64_lock", lock_o, 1);
    chk("clean_64_cnt", sh_cnt_o, 0);
    chk("clean_no_slip", slip_seen, 0);

    // Locked tolerance: 15 invalid per window, two windows.
    run_invalid(15);
    settle();
    chk("tol_w1_mid_lock", lock_o, 1);
    chk("tol_w1_mid_cnt", sh_cnt_o, 15);
    run_valid(49);
    settle();
    chk("tol_w1_lock", lock_o, 1);
    chk("tol_w1_cnt", sh_cnt_o, 0);
    run_valid(49);
    run_invalid(15);
    settle();
    chk("tol_w2_lock", lock_o, 1);
    chk("tol_w2_cnt", sh_cnt_o, 0);

    // Loss of lock: 16 x 2'b00.
    for (int i = 0; i < 15; i++) step(1'b1, 2'b00);
    settle();
    chk("loss_15_lock", lock_o, 1);
    step(1'b1, 2'b00);
    settle();
    chk("loss_16_lock", lock_o, 0);
    chk("loss_16_slip", slip_o, 1);
    chk("loss_16_cnt", sh_cnt_o, 0);
    // WAIT ignores even invalid headers.
    step(1'b1, 2'b11);
    settle();
    chk("loss_slip_pulse", slip_o, 0);
    step(1'b1, 2'b11);
    step(1'b1, 2'b11);
    settle();
    chk("wait_no_reslip", slip_o, 0);

    // Slip during acquisition after 10 valid headers.
    run_valid(10);
    settle();
    chk("acq_10_cnt", sh_cnt_o, 10);
    step(1'b1, 2'b11);
    settle();
    chk("acq_slip", slip_o, 1);
    chk("acq_slip_cnt", sh_cnt_o, 0);
    step(1'b1, 2'b00);
    step(1'b1, 2'b00);
    step(1'b1, 2'b00);
    settle();
    chk("acq_wait_slip", slip_o, 0);
    run_valid(63);
    settle();
    chk("reacq_63_lock", lock_o, 0);
    run_valid(1);
    settle();
    chk("reacq_64_lock", lock_o, 1);

    // Boundary: 64th header of window is also 16th invalid.
    run_valid(48);
    run_invalid(15);
    settle();
    chk("bnd_63_lock", lock_o, 1);
    chk("bnd_63_cnt", sh_cnt_o, 63);
    step(1'b1, 2'b11);
    settle();
    chk("bnd_64_lock", lock_o, 0);
    chk("bnd_64_slip", slip_o, 1);
    chk("bnd_64_cnt", sh_cnt_o, 0);
    step(1'b0, 2'b00);
    step(1'b0, 2'b00);
    step(1'b0, 2'b00);
    run_valid(64);
    settle();
    chk("bnd_relock", lock_o, 1);

    // Asynchronous reset between edges.
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async_lock", lock_o, 0);
    chk("async_slip", slip_o, 0);
    chk("async_cnt", sh_cnt_o, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive_push(1'b0, 2'b00);

    // Gapped traffic: idle cycles carry garbage headers that must be ignored.
    for (int i = 0; i < 64; i++) begin
      step(1'b0, 2'b11);
      step(1'b1, (i % 2 == 0) ? 2'b10 : 2'b01);
      if (i == 31) begin
        settle();
        chk("gap_32_cnt", sh_cnt_o, 32);
        chk("gap_32_lock", lock_o, 0);
      end
    end
    settle();
    chk("gap_lock", lock_o, 1);
    chk("gap_cnt", sh_cnt_o, 0);

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
